// File: rtl/pipeline_ctrl_param.sv
// Hazard/exception controller: prefix stall mask, bubble insertion,
// deferred exception redirect with programmable flush length.
module pipeline_ctrl_param #(
  parameter int STAGES = 6,
  parameter int ADDR_W = 32,
  parameter int EXC_W = 5,
  parameter logic [EXC_W-1:0] EXC_ERET = EXC_W'('h0e),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'hbfc0_0380),
  parameter logic [ADDR_W-1:0] INIT_PC = ADDR_W'(32'hbfc0_0000),
  parameter int FLUSH_LEN = 1,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              stall_all,
  input  logic [EXC_W-1:0]  exception_type,
  input  logic [ADDR_W-1:0] cp0_epc,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic              flush,
  output logic [ADDR_W-1:0] exc_pc,
  output logic              exc_pending,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int FL_W = $clog2(FLUSH_LEN + 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [FL_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAGES-1:0] mask, bub;
  logic              any;
  logic              exc_in;
  logic [ADDR_W-1:0] exc_tgt;

  // mask[i] set when any stage at or above i requests a stall
  always_comb begin
    mask = '0;
    bub = '0;
    any = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      any = any | stall_req[i];
      mask[i] = any;
    end
    for (int i = 1; i < STAGES; i++) begin
      bub[i] = mask[i-1] & ~mask[i];
    end
  end

  assign exc_in = (exception_type != '0);
  assign exc_tgt = (exception_type == EXC_ERET) ? cp0_epc : EXC_VECTOR;

  always_comb begin
    stall = '0;
    bubble = '0;
    unique case (state_q)
      RUN: begin
        if (stall_all) begin
          stall = '1;
        end else begin
          stall = mask;
          bubble = bub;
        end
      end
      HOLD: stall = '1;
      FLUSH: if (stall_all) stall = '1;
      default: stall = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    fcnt_d = fcnt_q;
    unique case (state_q)
      RUN: begin
        if (exc_in) begin
          tgt_d = exc_tgt;
          fcnt_d = '0;
          state_d = stall_all ? HOLD : FLUSH;
        end
      end
      HOLD: if (!stall_all) state_d = FLUSH;
      FLUSH: begin
        if (!stall_all) begin
          if (fcnt_q == FL_LAST) state_d = RUN;
          else fcnt_d = fcnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (|stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q <= INIT_PC;
      fcnt_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      fcnt_q <= fcnt_d;
      cnt_q <= cnt_d;
    end
  end

  assign flush = (state_q == FLUSH);
  assign exc_pc = flush ? tgt_q : INIT_PC;
  assign exc_pending = (state_q == HOLD);
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_param.sv
// Directed bench: default controller plus a FLUSH_LEN=3, CNT_W=4 variant.
module tb_pipeline_ctrl_param;

  localparam logic [31:0] VEC = 32'hbfc0_0380;
  localparam logic [31:0] INIT = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_req = '0;
  logic        stall_all = 1'b0;
  logic [4:0]  exception_type = '0;
  logic [31:0] cp0_epc = '0;

  logic [5:0]  stall, bubble, stall2, bubble2;
  logic        flush, pend, flush2, pend2;
  logic [31:0] exc_pc, exc_pc2, cyc;
  logic [3:0]  cyc2;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_param u_dut (
    .clk(clk), .rst(rst), .stall_req(stall_req),
    .stall_all(stall_all), .exception_type(exception_type),
    .cp0_epc(cp0_epc), .stall(stall), .bubble(bubble),
    .flush(flush), .exc_pc(exc_pc), .exc_pending(pend),
    .stall_cycles(cyc)
  );

  pipeline_ctrl_param #(.FLUSH_LEN(3), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .stall_req(stall_req),
    .stall_all(stall_all), .exception_type(exception_type),
    .cp0_epc(cp0_epc), .stall(stall2), .bubble(bubble2),
    .flush(flush2), .exc_pc(exc_pc2), .exc_pending(pend2),
    .stall_cycles(cyc2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nxt();
  endtask

  initial begin
    idle(2);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bubble", 32'(bubble), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_pc", exc_pc, INIT);
    chk("rst_cnt", cyc, 0);
    rst = 1'b0;
    nxt();
    chk("idle_bubble", 32'(bubble), 0);

    // stall from stage 2
    stall_req = 6'b000100;
    #1;
    chk("t1_stall", 32'(stall), 32'b000111);
    chk("t1_bubble", 32'(bubble), 32'b001000);
    chk("t1_flush", 32'(flush), 0);
    nxt();
    chk("t1_cnt", cyc, 1);

    stall_req = 6'b100000;
    #1;
    chk("t2_stall_top", 32'(stall), 32'b111111);
    chk("t2_bubble_top", 32'(bubble), 0);
    nxt();
    stall_req = 6'b000101;
    #1;
    chk("t2_stall", 32'(stall), 32'b000111);
    chk("t2_bubble", 32'(bubble), 32'b001000);
    nxt();
    chk("t2_cnt", cyc, 3);
    stall_req = '0;

    // general exception
    exception_type = 5'h04;
    #1;
    chk("t3_flush_lat", 32'(flush), 0);
    nxt();
    exception_type = '0;
    chk("t3_flush", 32'(flush), 1);
    chk("t3_pc", exc_pc, VEC);
    chk("t3_flush2", 32'(flush2), 1);
    nxt();
    chk("t3_unflush", 32'(flush), 0);
    chk("t3_pc_init", exc_pc, INIT);
    chk("t3_len3_c2", 32'(flush2), 1);
    nxt();
    chk("t3_len3_c3", 32'(flush2), 1);
    chk("t3_len3_pc", exc_pc2, VEC);
    nxt();
    chk("t3_len3_end", 32'(flush2), 0);

    // ERET, epc changes after capture
    exception_type = 5'h0e;
    cp0_epc = 32'h8000_1234;
    nxt();
    exception_type = '0;
    cp0_epc = 32'hdead_beef;
    #1;
    chk("t4_flush", 32'(flush), 1);
    chk("t4_pc", exc_pc, 32'h8000_1234);
    nxt();
    chk("t4_end", 32'(flush), 0);
    idle(3);

    // exception deferred by stall_all
    stall_all = 1'b1;
    exception_type = 5'h04;
    #1;
    chk("t5_stall", 32'(stall), 32'b111111);
    chk("t5_pend0", 32'(pend), 0);
    nxt();
    chk("t5_pend", 32'(pend), 1);
    chk("t5_noflush", 32'(flush), 0);
    exception_type = 5'h0e;
    cp0_epc = 32'h1234_5678;
    nxt();
    chk("t5_pend_b", 32'(pend), 1);
    chk("t5_stall_h", 32'(stall), 32'b111111);
    exception_type = '0;
    nxt();
    stall_all = 1'b0;
    #1;
    chk("t5_drop_stall", 32'(stall), 32'b111111);
    nxt();
    chk("t5_flush", 32'(flush), 1);
    chk("t5_pc", exc_pc, VEC);
    chk("t5_pend_clr", 32'(pend), 0);
    chk("t5_fl_stall", 32'(stall), 0);
    chk("t5_cnt", cyc, 7);
    nxt();
    chk("t5_end", 32'(flush), 0);
    idle(3);

    // stall_all freezes the flush length
    exception_type = 5'h04;
    nxt();
    exception_type = '0;
    stall_all = 1'b1;
    #1;
    chk("t5f_stall", 32'(stall), 32'b111111);
    chk("t5f_flush", 32'(flush), 1);
    nxt();
    stall_all = 1'b0;
    chk("t5f_frozen", 32'(flush), 1);
    chk("t5f_pc", exc_pc, VEC);
    nxt();
    chk("t5f_end", 32'(flush), 0);
    chk("t5f_cnt", cyc, 8);
    idle(5);

    // reset during second flush cycle of the long variant
    exception_type = 5'h04;
    nxt();
    exception_type = '0;
    chk("t6_c1", 32'(flush2), 1);
    nxt();
    chk("t6_c2", 32'(flush2), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_flush", 32'(flush2), 0);
    chk("t6_rst_pc", exc_pc2, INIT);
    chk("t6_rst_cnt", 32'(cyc2), 0);
    chk("t6_rst_cnt1", cyc, 0);
    nxt();
    rst = 1'b0;
    nxt();
    chk("t6_no_resume", 32'(flush2), 0);

    // saturation of the 4-bit counter
    stall_req = 6'b000001;
    #1;
    chk("k0_stall", 32'(stall), 32'b000001);
    chk("k0_bubble", 32'(bubble), 32'b000010);
    idle(15);
    chk("sat_15", 32'(cyc2), 15);
    idle(5);
    stall_req = '0;
    chk("sat_hold", 32'(cyc2), 32'hf);
    chk("cnt32_20", cyc, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
